// File: rtl/digi_ota_cal_ctrl_if.sv
// Control/trim bundle between the tile controller (master) and the OTA
// offset-calibration sequencer (slave).
interface digi_ota_cal_ctrl_if #(
  parameter int TRIM_W = 5
);
  logic              start;
  logic              abort;
  logic              ota_out;
  logic              cal_short;
  logic              ota_en;
  logic [TRIM_W-1:0] trim;
  logic              busy;
  logic              done;
  logic              cal_fail;

  modport master (
    output start, abort, ota_out,
    input  cal_short, ota_en, trim, busy, done, cal_fail
  );

  modport slave (
    input  start, abort, ota_out,
    output cal_short, ota_en, trim, busy, done, cal_fail
  );
endinterface

// File: rtl/digi_ota_cal_ctrl.sv
// Successive-approximation offset-trim sequencer for the digital OTA.
// Optional periodic recalibration when DIGI_OTA_RECAL_EN is defined.
module digi_ota_cal_ctrl #(
  parameter int TRIM_W        = 5,
  parameter int SETTLE_CYCLES = 16,
  parameter int RECAL_PERIOD  = 65536
) (
  input  logic               clk,
  input  logic               rst,
  digi_ota_cal_ctrl_if.slave cal_if
);
  localparam int CNT_W = $clog2(SETTLE_CYCLES);
  localparam int IDX_W = $clog2(TRIM_W);
  localparam logic [TRIM_W-1:0] TRIM_MID = TRIM_W'(1) << (TRIM_W - 1);

  if (TRIM_W < 2 || SETTLE_CYCLES < 4 || RECAL_PERIOD < 2) begin : g_param_chk
    $error("digi_ota_cal_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_SAMPLE, S_DECIDE, S_FINISH
  } state_t;

  state_t            r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic [IDX_W-1:0]  r_idx, w_idx_next, w_idx_dec;
  logic [1:0]        r_samp_cnt, w_samp_cnt_next;
  logic [2:0]        r_samp, w_samp_next;
  logic [TRIM_W-1:0] r_trim, w_trim_next;
  logic [TRIM_W-1:0] r_shadow_trim, w_shadow_trim_next;
  logic              r_ota_en, w_ota_en_next;
  logic              r_shadow_en, w_shadow_en_next;
  logic              r_cal_fail, w_cal_fail_next;
  logic              r_sync1, r_sync2;
  logic              w_busy, w_maj, w_start_req;

  assign w_busy    = (r_state == S_SETTLE) || (r_state == S_SAMPLE) || (r_state == S_DECIDE);
  assign w_maj     = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);
  assign w_idx_dec = r_idx - IDX_W'(1);

`ifdef DIGI_OTA_RECAL_EN
  // Idle counter arms only after a good calibration; its terminal count acts as a start.
  logic [31:0] r_idle_cnt;
  logic        r_cal_ok;
  logic        w_auto_start;

  assign w_auto_start = (r_state == S_IDLE) && r_cal_ok && (r_idle_cnt == 32'(RECAL_PERIOD - 1));
  assign w_start_req  = cal_if.start | w_auto_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle_cnt <= '0;
      r_cal_ok   <= 1'b0;
    end else begin
      if (r_state == S_FINISH)
        r_cal_ok <= 1'b1;
      if ((r_state == S_FINISH) || w_start_req || cal_if.abort)
        r_idle_cnt <= '0;
      else if ((r_state == S_IDLE) && r_cal_ok)
        r_idle_cnt <= r_idle_cnt + 32'd1;
    end
  end
`else
  assign w_start_req = cal_if.start;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= cal_if.ota_out;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_idx         <= '0;
      r_samp_cnt    <= '0;
      r_samp        <= '0;
      r_trim        <= TRIM_MID;
      r_shadow_trim <= TRIM_MID;
      r_ota_en      <= 1'b0;
      r_shadow_en   <= 1'b0;
      r_cal_fail    <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_next;
      r_idx         <= w_idx_next;
      r_samp_cnt    <= w_samp_cnt_next;
      r_samp        <= w_samp_next;
      r_trim        <= w_trim_next;
      r_shadow_trim <= w_shadow_trim_next;
      r_ota_en      <= w_ota_en_next;
      r_shadow_en   <= w_shadow_en_next;
      r_cal_fail    <= w_cal_fail_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = r_cnt;
    w_idx_next         = r_idx;
    w_samp_cnt_next    = r_samp_cnt;
    w_samp_next        = r_samp;
    w_trim_next        = r_trim;
    w_shadow_trim_next = r_shadow_trim;
    w_ota_en_next      = r_ota_en;
    w_shadow_en_next   = r_shadow_en;
    w_cal_fail_next    = r_cal_fail;

    case (r_state)
      S_IDLE: begin
        if (w_start_req && !cal_if.abort) begin
          w_shadow_trim_next = r_trim;
          w_shadow_en_next   = r_ota_en;
          w_idx_next         = IDX_W'(TRIM_W - 1);
          w_trim_next        = TRIM_MID;
          w_ota_en_next      = 1'b0;
          w_cal_fail_next    = 1'b0;
          w_cnt_next         = CNT_W'(SETTLE_CYCLES - 1);
          w_state_next       = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_cnt == '0) begin
          w_samp_cnt_next = '0;
          w_state_next    = S_SAMPLE;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      S_SAMPLE: begin
        w_samp_next = {r_samp[1:0], r_sync2};
        if (r_samp_cnt == 2'd2) w_state_next = S_DECIDE;
        else                    w_samp_cnt_next = r_samp_cnt + 2'd1;
      end
      S_DECIDE: begin
        // Majority high means the OTA reads above threshold: this bit overshoots.
        if (w_maj) w_trim_next[r_idx] = 1'b0;
        if (r_idx == '0) begin
          w_ota_en_next   = 1'b1;
          w_cal_fail_next = (w_trim_next == '0) || (&w_trim_next);
          w_state_next    = S_FINISH;
        end else begin
          w_idx_next              = w_idx_dec;
          w_trim_next[w_idx_dec]  = 1'b1;
          w_cnt_next              = CNT_W'(SETTLE_CYCLES - 1);
          w_state_next            = S_SETTLE;
        end
      end
      S_FINISH: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase

    if (w_busy && cal_if.abort) begin
      w_trim_next     = r_shadow_trim;
      w_ota_en_next   = r_shadow_en;
      w_cal_fail_next = 1'b0;
      w_state_next    = S_IDLE;
    end
  end

  assign cal_if.cal_short = w_busy;
  assign cal_if.busy      = w_busy;
  assign cal_if.done      = (r_state == S_FINISH);
  assign cal_if.ota_en    = r_ota_en;
  assign cal_if.trim      = r_trim;
  assign cal_if.cal_fail  = r_cal_fail;
endmodule

// File: tb/tb_digi_ota_cal_ctrl.sv
// Directed bench for digi_ota_cal_ctrl: behavioural OTA threshold model,
// scoreboard of expected final trim codes, immediate-assertion checks.
`timescale 1ns/1ps
module tb_digi_ota_cal_ctrl;
  localparam int TRIM_W = 5;
  localparam int SETTLE = 16;
  localparam int RECAL  = 200;
  localparam int LAT    = TRIM_W * (SETTLE + 4) + 1;

  typedef struct {
    int trim;
    int fail;
  } exp_t;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic ota_dly = 1'b0;
  logic glitch  = 1'b0;
  int   th      = 12;
  int   n_asrt  = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  digi_ota_cal_ctrl_if #(.TRIM_W(TRIM_W)) bus ();

  digi_ota_cal_ctrl #(
    .TRIM_W(TRIM_W),
    .SETTLE_CYCLES(SETTLE),
    .RECAL_PERIOD(RECAL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cal_if(bus)
  );

  always #5 clk = ~clk;

  // OTA reads high once the trim reaches the threshold, one cycle late.
  always @(posedge clk) ota_dly <= (int'(bus.trim) >= th);
  assign bus.ota_out = ota_dly ^ glitch;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_sar(input int thr);
    int code = 0;
    for (int b = TRIM_W - 1; b >= 0; b--) begin
      code = code | (1 << b);
      if (code >= thr) code = code & ~(1 << b);
    end
    return code;
  endfunction

  task automatic push_exp();
    exp_t e;
    e.trim = ref_sar(th);
    e.fail = (e.trim == 0 || e.trim == (1 << TRIM_W) - 1) ? 1 : 0;
    sb.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " trim"},      bus.trim, 16);
    chk({tag, " ota_en"},    bus.ota_en, 0);
    chk({tag, " cal_short"}, bus.cal_short, 0);
    chk({tag, " busy"},      bus.busy, 0);
    chk({tag, " done"},      bus.done, 0);
    chk({tag, " cal_fail"},  bus.cal_fail, 0);
  endtask

  task automatic run_to_done(input string tag, input int glitch_n, input int restart_n);
    int   n;
    bit   seen;
    exp_t e;
    n = 1;
    seen = 1'b0;
    while (!seen && n <= LAT + 10) begin
      glitch    = (n == glitch_n);
      bus.start = (n == restart_n);
      if (n == 1) begin
        chk({tag, " busy@1"},      bus.busy, 1);
        chk({tag, " short@1"},     bus.cal_short, 1);
        chk({tag, " ota_en@1"},    bus.ota_en, 0);
        chk({tag, " cal_fail@1"},  bus.cal_fail, 0);
        chk({tag, " trim@1"},      bus.trim, 16);
      end
      if (bus.done) seen = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    glitch    = 1'b0;
    bus.start = 1'b0;
    chk({tag, " done seen"}, seen, 1);
    chk({tag, " sb nonempty"}, (sb.size() > 0), 1);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      $display("cal %s: trim=%0d cal_fail=%0d latency=%0d (want trim=%0d cal_fail=%0d latency=%0d)",
               tag, bus.trim, bus.cal_fail, n, e.trim, e.fail, LAT);
      chk({tag, " latency"},   n, LAT);
      chk({tag, " trim"},      bus.trim, e.trim);
      chk({tag, " cal_fail"},  bus.cal_fail, e.fail);
      chk({tag, " ota_en"},    bus.ota_en, 1);
      chk({tag, " cal_short"}, bus.cal_short, 0);
      chk({tag, " busy"},      bus.busy, 0);
      @(negedge clk);
      chk({tag, " done 1cyc"}, bus.done, 0);
    end
  endtask

  task automatic check_idle(input string tag, input int trim_exp);
    chk({tag, " busy"},      bus.busy, 0);
    chk({tag, " cal_short"}, bus.cal_short, 0);
    chk({tag, " ota_en"},    bus.ota_en, 1);
    chk({tag, " trim"},      bus.trim, trim_exp);
  endtask

  initial begin
    int cnt;
    int m;
    bus.start = 1'b0;
    bus.abort = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // Nominal sweep
    th = 12;
    push_exp();
    pulse_start();
    run_to_done("nominal", 0, 0);

    // Saturation low then high
    th = 0;
    push_exp();
    pulse_start();
    run_to_done("stuck1", 0, 0);
    th = 32;
    push_exp();
    pulse_start();
    run_to_done("stuck0", 0, 0);

    // Glitch during bit-3 sampling, plus a start while busy
    th = 12;
    push_exp();
    pulse_start();
    run_to_done("glitch", 36, 50);

    // Abort 40 cycles into a calibration
    pulse_start();
    repeat (39) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_idle("abort", 11);
    chk("abort cal_fail", bus.cal_fail, 0);
    cnt = 0;
    for (int k = 0; k < 120; k++) begin
      if (bus.done) cnt++;
      @(negedge clk);
    end
    chk("abort no done", cnt, 0);
    $display("abort: trim=%0d busy=%0d", bus.trim, bus.busy);

    // start and abort together in IDLE, then abort alone
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check_idle("start+abort", 11);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_idle("abort idle", 11);

`ifdef DIGI_OTA_RECAL_EN
    push_exp();
    pulse_start();
    run_to_done("recal seed", 0, 0);
    m = 0;
    while (!bus.busy && m < 2 * RECAL) begin
      @(negedge clk);
      m++;
    end
    $display("recal: busy after %0d idle cycles", m);
    chk("recal delay", m, RECAL);
    repeat (20) @(negedge clk);
`else
    m = 0;
    pulse_start();
    repeat (30) @(negedge clk);
`endif

    // Reset in the middle of a calibration
    chk("pre-rst busy", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("mid rst");
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.busy) cnt++;
    end
    chk("post-rst no cal", cnt, 0);
    $display("post-rst: busy cycles=%0d", cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
